seq_mult_8: RTL
===============

# seq_mult_8

Sequential unsigned 8×8 shift-and-add multiplier that produces a 16-bit product in 8 iterations. It sits directly upstream of the 8-bit ripple-carry adder. Each cycle it feeds the adder the running partial product and the multiplicand, then consumes the adder's sum and carry-out. It gives the ALU a multiply operation without a combinational array multiplier.

## Interface
- `N`, default 8: operand width. Only 8 is supported, because the adder instance is fixed at 8 bits.
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a multiply. Sampled only when the block can accept it.
- `a`, in, N: multiplicand. Captured on the accepting edge.
- `b`, in, N: multiplier. Captured on the accepting edge.
- `busy`, out, 1: high while iterating.
- `done`, out, 1: one-cycle pulse. Marks that `product` holds a new result.
- `product`, out, 2N: result register. Holds its value until the next result.

## Operation
- **States:**
  - `IDLE`: waiting for work.
  - `RUN`: iterating.
  - `DONE`: result-strobe cycle.
- **Internal registers:**
  - `M[N-1:0]`: multiplicand.
  - `P[2N-1:0]`: accumulator/multiplier.
  - `cnt[3:0]`: iteration count.
- **Accept:**
  - In `IDLE` or `DONE` with `start=1`: `M←a`, `P←{N'b0, b}`, `cnt←0`, next state `RUN`.
- **RUN iteration:**
  - Adder inputs are `P[2N-1:N]`, `M & {N{P[0]}}` and `c_in=0`.
  - Adder outputs are `sum` and `c`.
  - Update `P←{c, sum, P[N-1:1]}` and `cnt←cnt+1`.
  - When `P[0]=0` the masked operand is 0, so the high half passes through unchanged with `c=0`.
- **Exit:**
  - On the RUN edge where `cnt==N-1`, the iteration result is written to `P`.
  - On that same edge, `product←` the updated `P` value, and the next state is `DONE`.
- **DONE:**
  - `done=1`, `busy=0`.
  - Next state is `RUN` if `start=1` (accepted as above), otherwise `IDLE`.
- **start while RUN:** ignored. Not queued, and `M` and `P` are not disturbed.
- **Arithmetic:**
  - Unsigned only.
  - The 2N-bit product cannot overflow, so there is no overflow flag.
  - The adder carry-out becomes the new bit 2N-1 of `P` before the shift.
- **Reset** (any state, including mid-RUN):
  - `state←IDLE`; `busy=0`, `done=0`, `product=0`; `P`, `M` and `cnt` cleared.
  - Any in-flight multiply is abandoned with no `done`.
  - `start` is ignored in the reset cycle.
- **Outputs:**
  - `busy` is decoded from `state==RUN`.
  - `done` is decoded from `state==DONE`.
  - `product` changes only on a RUN→DONE transition or on reset.

## Timing
- The accepting edge ends cycle 0.
  - Cycles 1..N: `busy=1`.
  - Cycle N+1: `done=1`, and `product` is valid.
- Latency is start-to-`done` = N+1 cycles (9 for N=8).
- Throughput: one multiply every N+1 cycles when `start` is held high. DONE accepts directly, with no idle bubble.
- The adder path is combinational within one cycle: `P`/`M` register → adder → `P` register.

## Structure
- Shared package:
  - `N_WIDTH=8`.
  - State encoding `ST_IDLE=2'd0`, `ST_RUN=2'd1`, `ST_DONE=2'd2`.
  - Iteration terminal count `CNT_LAST=N_WIDTH-1`.
- One sub-module instance: the existing `Add_rca_8` ripple-carry adder, with `c_in` tied to 0.
- Everything else lives inline in `seq_mult_8`: the FSM, the counter, and the shift register.
- No new sub-modules.

## Test plan
- **Basic multiply.** Reset for 2 cycles, then `start` with a=13, b=11.
  - `busy` is high for 8 cycles.
  - `done` pulses in cycle 9 with `product`=16'h008F.
  - `done` is low the next cycle.
- **Extremes.**
  - a=8'hFF, b=8'hFF → `product`=16'hFE01.
  - a=0, b=8'hA5 → `product`=0.
  - a=8'h80, b=8'h02 → `product`=16'h0100.
- **start during RUN.** Pulse `start` with a=3, b=5 in cycle 4 of a 7×9 multiply.
  - Result is 63 at cycle 9.
  - No second `done`, `busy` drops.
- **Back-to-back.** Hold `start` high with 6×7, then 200×200.
  - `done` at cycle 9 shows 42.
  - Second `done` at cycle 18 shows 40000 (16'h9C40).
  - `busy` is low only during the DONE cycles.
- **Reset mid-operation.** Assert `rst` in cycle 5 of a multiply.
  - Next cycle shows `busy=0`, `done=0`, `product=0`.
  - No `done` ever appears for the aborted operation.
  - A fresh 2×3 then yields 6.
- **Random check.** 500 random (a, b) pairs compared against a reference a*b.
  - `done` spacing must be exactly 9 cycles under continuous `start`.

Source files
------------

// File: rtl/seq_mult_8_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package seq_mult_8_pkg;

    localparam int N_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The iteration counter is 4 bits wide, so the terminal count is sized to match.
    localparam logic [3:0] CNT_LAST = 4'(N_WIDTH - 1);

endpackage

// File: rtl/Add_rca_8.sv
// 8-bit ripple-carry adder: sum = a + b + c_in, with the carry-out on c.
module Add_rca_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c
);

    logic [8:0] carry;

    always_comb begin
        carry[0] = c_in;
        for (int i = 0; i < 8; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c = carry[8];

endmodule

// File: rtl/seq_mult_8.sv
// Unsigned 8x8 shift-and-add multiplier: one adder pass per cycle, 16-bit product after 8 iterations.
module seq_mult_8
    import seq_mult_8_pkg::*;
#(
    parameter int N = N_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    state_e         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [2*N-1:0] p_q, p_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;

    logic [N-1:0]   add_b;
    logic [N-1:0]   add_sum;
    logic           add_c;
    logic [2*N-1:0] iter_p;

    // Multiplier LSB gates the multiplicand; a zero bit passes the high half through unchanged.
    assign add_b = m_q & {N{p_q[0]}};

    Add_rca_8 u_add (
        .a    (p_q[2*N-1:N]),
        .b    (add_b),
        .c_in (1'b0),
        .sum  (add_sum),
        .c    (add_c)
    );

    // Carry-out lands in the top bit as the whole register shifts right by one.
    assign iter_p = {add_c, add_sum, p_q[N-1:1]};

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    m_d     = a;
                    p_d     = {{N{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                p_d   = iter_p;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    product_d = iter_p;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule
